// File: rtl/alu_core_if.sv
// Operation request and result bus between decode and write-back.
// The master drives start/opcode/operands; the slave returns busy/done, the result and flags.
interface alu_core_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             zero;
   logic             overflow;
   logic             illegal;

   modport master (
      output start, opcode, ain, bin,
      input  busy, done, out, carry, zero, overflow, illegal
   );

   modport slave (
      input  start, opcode, ain, bin,
      output busy, done, out, carry, zero, overflow, illegal
   );
endinterface

// File: rtl/alu_core.sv
// Multi-cycle ALU: add/sub/invert complete 1 edge after acceptance, shifts by N take N+1 edges.
// One operation at a time: start is ignored while busy; done pulses one cycle and start may be accepted in that same cycle.
module alu_core #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clock,
   input logic       reset,
   alu_core_if.slave bus
);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_INV = 4'b0011;
   localparam logic [3:0] OP_LSR = 4'b1000;
   localparam logic [3:0] OP_LSL = 4'b1001;
   localparam logic [3:0] OP_ASR = 4'b1010;
   localparam logic [SHW-1:0] CNT_ONE = 1;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] b_q;
   logic [SHW-1:0]   count_q;
   logic             last_q;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] shift_nxt;
   logic             shift_bit;
   logic             is_shift;

   assign add_sum = {1'b0, work_q} + {1'b0, b_q};
   assign sub_sum = {1'b0, work_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      shift_nxt = work_q;
      shift_bit = 1'b0;
      is_shift  = 1'b1;
      case (op_q)
         OP_LSR: begin
            shift_nxt = {1'b0, work_q[WIDTH-1:1]};
            shift_bit = work_q[0];
         end
         OP_LSL: begin
            shift_nxt = {work_q[WIDTH-2:0], 1'b0};
            shift_bit = work_q[WIDTH-1];
         end
         OP_ASR: begin
            shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            shift_bit = work_q[0];
         end
         default: is_shift = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         op_q         <= '0;
         work_q       <= '0;
         b_q          <= '0;
         count_q      <= '0;
         last_q       <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.out      <= '0;
         bus.carry    <= 1'b0;
         bus.zero     <= 1'b0;
         bus.overflow <= 1'b0;
         bus.illegal  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.opcode;
                  work_q   <= bus.ain;
                  b_q      <= bus.bin;
                  count_q  <= bus.bin[SHW-1:0];
                  last_q   <= 1'b0;
                  bus.busy <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (is_shift && count_q != '0) begin
                  work_q  <= shift_nxt;
                  last_q  <= shift_bit;
                  count_q <= count_q - CNT_ONE;
               end else begin
                  bus.done    <= 1'b1;
                  bus.busy    <= 1'b0;
                  bus.illegal <= 1'b0;
                  state       <= IDLE;
                  case (op_q)
                     OP_ADD: begin
                        bus.out      <= add_sum[WIDTH-1:0];
                        bus.carry    <= add_sum[WIDTH];
                        bus.zero     <= (add_sum[WIDTH-1:0] == '0);
                        bus.overflow <= (work_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                        (add_sum[WIDTH-1] != work_q[WIDTH-1]);
                     end
                     OP_SUB: begin
                        bus.out      <= sub_sum[WIDTH-1:0];
                        bus.carry    <= sub_sum[WIDTH];
                        bus.zero     <= (sub_sum[WIDTH-1:0] == '0);
                        bus.overflow <= (work_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                        (sub_sum[WIDTH-1] != work_q[WIDTH-1]);
                     end
                     OP_INV: begin
                        bus.out      <= ~work_q;
                        bus.carry    <= 1'b0;
                        bus.zero     <= (~work_q == '0);
                        bus.overflow <= 1'b0;
                     end
                     OP_LSR, OP_LSL, OP_ASR: begin
                        bus.out      <= work_q;
                        bus.carry    <= last_q;
                        bus.zero     <= (work_q == '0);
                        bus.overflow <= 1'b0;
                     end
                     // Undefined opcode: result and flags keep their previous values.
                     default: bus.illegal <= 1'b1;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core at WIDTH=8: expected results are queued at issue and compared at done.
module tb_alu_core;

   typedef struct packed {
      logic [7:0] out;
      logic       carry;
      logic       zero;
      logic       ovf;
      logic       ill;
      logic [7:0] lat;
   } res_t;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;
   res_t m_prev;
   res_t exp_q[$];

   alu_core_if #(.WIDTH(8)) bus ();

   alu_core #(.WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t e;
      int n, sa, sb, r;
      logic signed [7:0] as8;
      e     = m_prev;
      e.ill = 1'b0;
      e.ovf = 1'b0;
      e.lat = 8'd1;
      n     = int'(b[2:0]);
      sa    = int'($signed(a));
      sb    = int'($signed(b));
      as8   = a;
      case (op)
         4'b0001: begin
            r       = int'(a) + int'(b);
            e.out   = a + b;
            e.carry = (r > 255);
            e.ovf   = (sa + sb > 127) || (sa + sb < -128);
         end
         4'b0010: begin
            e.out   = a - b;
            e.carry = (a >= b);
            e.ovf   = (sa - sb > 127) || (sa - sb < -128);
         end
         4'b0011: begin
            e.out   = ~a;
            e.carry = 1'b0;
         end
         4'b1000: begin
            e.out   = a >> n;
            e.carry = (n == 0) ? 1'b0 : a[n-1];
            e.lat   = 8'(n + 1);
         end
         4'b1001: begin
            e.out   = a << n;
            e.carry = (n == 0) ? 1'b0 : a[8-n];
            e.lat   = 8'(n + 1);
         end
         4'b1010: begin
            e.out   = as8 >>> n;
            e.carry = (n == 0) ? 1'b0 : a[n-1];
            e.lat   = 8'(n + 1);
         end
         default: begin
            e     = m_prev;
            e.ill = 1'b1;
            e.lat = 8'd1;
            return e;
         end
      endcase
      e.zero = (e.out == 8'h00);
      return e;
   endfunction

   // Called at a falling edge with the DUT idle (or in its done cycle); returns one falling edge after acceptance.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t e;
      e      = model(op, a, b);
      m_prev = e;
      exp_q.push_back(e);
      bus.start  = 1'b1;
      bus.opcode = op;
      bus.ain    = a;
      bus.bin    = b;
      @(negedge clock);
      bus.start  = 1'b0;
   endtask

   task automatic collect(input int lat0, output int lat, output bit to, output int busy_cnt);
      lat      = lat0;
      busy_cnt = 0;
      do begin
         @(negedge clock);
         lat++;
         if (bus.busy) busy_cnt++;
      end while (!bus.done && lat < 64);
      to = !bus.done;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({bus.busy, bus.done, bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %b want all zero",
                  {bus.busy, bus.done, bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal});
      end
      reset  = 1'b0;
      m_prev = '0;
      @(negedge clock);
   endtask

   task automatic test_add;
      res_t e; int lat, bc; bit to;
      issue(4'b0001, 8'h7F, 8'h01);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL add_busy: got %b want 1", bus.busy);
      end
      collect(0, lat, to, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
         n_fail++; $display("FAIL add_result: got %h/%b%b%b%b want %h/%b%b%b%b", bus.out, bus.carry,
                            bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
      end
      n_checks++;
      if (lat !== int'(e.lat)) begin
         n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, e.lat);
      end
   endtask

   task automatic test_back_to_back;
      res_t e; int lat, bc; bit to;
      @(negedge clock);
      issue(4'b0010, 8'h05, 8'h05);
      for (int i = 0; i < 2; i++) begin
         collect(0, lat, to, bc);
         e = exp_q.pop_front();
         n_checks++;
         if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
            n_fail++; $display("FAIL sub_result%0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, bus.out, bus.carry,
                               bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
         end
         n_checks++;
         if (lat !== int'(e.lat)) begin
            n_fail++; $display("FAIL sub_latency%0d: got %0d want %0d", i, lat, e.lat);
         end
         if (i == 0) issue(4'b0010, 8'h03, 8'h05);
      end
   endtask

   task automatic test_shift;
      res_t e; int lat, bc; bit to;
      logic [3:0] ops [5] = '{4'b1001, 4'b1001, 4'b1010, 4'b1000, 4'b1001};
      logic [7:0] as  [5] = '{8'hB1, 8'h5A, 8'h90, 8'h90, 8'h80};
      logic [7:0] bs  [5] = '{8'h03, 8'h00, 8'h02, 8'h02, 8'h0F};
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         issue(ops[i], as[i], bs[i]);
         collect(0, lat, to, bc);
         e = exp_q.pop_front();
         n_checks++;
         if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
            n_fail++; $display("FAIL shift_result%0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, bus.out, bus.carry,
                               bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
         end
         n_checks++;
         if (lat !== int'(e.lat) || bc !== int'(e.lat) - 1) begin
            n_fail++; $display("FAIL shift_timing%0d: got lat %0d busy %0d want lat %0d busy %0d",
                               i, lat, bc, e.lat, int'(e.lat) - 1);
         end
      end
   endtask

   task automatic test_illegal;
      res_t e; int lat, bc; bit to;
      @(negedge clock);
      issue(4'b1000, 8'h90, 8'h02);
      collect(0, lat, to, bc);
      void'(exp_q.pop_front());
      issue(4'b0111, 8'hFF, 8'hFF);
      issue_check: for (int i = 0; i < 2; i++) begin
         collect(0, lat, to, bc);
         e = exp_q.pop_front();
         n_checks++;
         if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
            n_fail++; $display("FAIL illegal_seq%0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, bus.out, bus.carry,
                               bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
         end
         if (i == 0) issue(4'b0001, 8'h01, 8'hFF);
      end
   endtask

   task automatic test_ignore_start;
      res_t e; int lat, bc; bit to;
      @(negedge clock);
      issue(4'b1000, 8'hC1, 8'h07);
      repeat (2) @(negedge clock);
      bus.start  = 1'b1;
      bus.opcode = 4'b0001;
      bus.ain    = 8'h55;
      bus.bin    = 8'h22;
      @(negedge clock);
      bus.start  = 1'b0;
      collect(3, lat, to, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
         n_fail++; $display("FAIL ignore_start: got %h/%b%b%b%b want %h/%b%b%b%b", bus.out, bus.carry,
                            bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
      end
      n_checks++;
      if (lat !== int'(e.lat)) begin
         n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, e.lat);
      end
   endtask

   task automatic test_reset_midshift;
      res_t e; int lat, bc, seen; bit to;
      @(negedge clock);
      issue(4'b1000, 8'hF0, 8'h07);
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== 13'h0) begin
         n_fail++; $display("FAIL reset_midshift: got %b want all zero",
                            {bus.busy, bus.done, bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal});
      end
      @(negedge clock);
      reset  = 1'b0;
      m_prev = '0;
      seen   = 0;
      repeat (10) begin
         @(negedge clock);
         if (bus.done) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
      end
      issue(4'b0001, 8'h10, 8'h20);
      collect(0, lat, to, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
         n_fail++; $display("FAIL after_reset: got %h/%b%b%b%b want %h/%b%b%b%b", bus.out, bus.carry,
                            bus.zero, bus.overflow, bus.illegal, e.out, e.carry, e.zero, e.ovf, e.ill);
      end
   endtask

   task automatic test_random;
      res_t e; int lat, bc; bit to;
      logic [3:0] opset [8] = '{4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b0000, 4'b1111};
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
         issue(opset[$urandom_range(7)], 8'($urandom), 8'($urandom));
         collect(0, lat, to, bc);
         e = exp_q.pop_front();
         n_checks++;
         if (to || lat !== int'(e.lat) ||
             {bus.out, bus.carry, bus.zero, bus.overflow, bus.illegal} !== {e.out, e.carry, e.zero, e.ovf, e.ill}) begin
            n_fail++; $display("FAIL random%0d: got %h/%b%b%b%b lat %0d want %h/%b%b%b%b lat %0d", i, bus.out,
                               bus.carry, bus.zero, bus.overflow, bus.illegal, lat,
                               e.out, e.carry, e.zero, e.ovf, e.ill, e.lat);
         end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      m_prev     = '0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.opcode = 4'h0;
      bus.ain    = 8'h00;
      bus.bin    = 8'h00;
      test_reset;
      test_add;
      test_back_to_back;
      test_shift;
      test_illegal;
      test_ignore_start;
      test_reset_midshift;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Parametrised, multi-cycle successor to the 4-bit add/subtract unit.
- Adds operand width parameterisation, a start/busy/done handshake, status flags, and iterative shifts that move one bit per clock.
- Sits between the decode stage and the register write-back in the 8-bit CPU datapath.
- Results and flags are registered and held until the next completed operation.

Parameters:
- WIDTH, 8: operand and result width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from bin.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcode  in  4  operation select (encodings below).
- ain  in  WIDTH  operand A.
- bin  in  WIDTH  operand B. For shifts, bin[SHW-1:0] is the shift amount.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- out  out  WIDTH  registered result.
- carry  out  1  carry / no-borrow / last bit shifted out.
- zero  out  1  high when the result is all zeros.
- overflow  out  1  signed overflow (add and subtract only).
- illegal  out  1  high when the last completed opcode was undefined.

Behaviour:
- Opcodes:
  - 0001 ADD: out = ain + bin.
  - 0010 SUB: out = ain + ~bin + 1.
  - 0011 INV: out = ~ain.
  - 1000 LSR: logical right shift.
  - 1001 LSL: logical left shift.
  - 1010 ASR: arithmetic right shift.
  - All other codes are illegal.
- Reset (async): state=IDLE; busy, done, out, carry, zero, overflow, illegal all 0; latched operands and count cleared. An in-flight operation is discarded with no done pulse.
- States: IDLE, EXEC.
- IDLE, rising edge with start=1:
  - Latch opcode, ain into a working register, bin, and count = bin[SHW-1:0].
  - Go to EXEC; busy=1 after that edge.
- start while busy=1 is ignored. No queuing; the latched operands are not disturbed.
- EXEC for ADD, SUB, INV and illegal codes: on the next edge, write out and flags, pulse done=1, return to IDLE, busy=0. Latency is 1 edge after the accepting edge.
- EXEC for shifts:
  - Each edge with count != 0: shift the working register by 1, capture the bit shifted out, decrement count.
  - On the edge where count == 0: write out = working register, set carry = last captured bit (0 if the amount was 0), pulse done, return to IDLE.
  - Shift by N completes N+1 edges after acceptance.
  - Amount is bin mod WIDTH; a shift by WIDTH or more is not representable.
  - ASR replicates the MSB; LSL and LSR fill with 0.
- done:
  - High for exactly one cycle after the completing edge.
  - start may be asserted in that same cycle and is accepted, so back-to-back operations have no idle gap.
- Flags update only at completion and hold otherwise. zero = (out == 0) for every legal opcode.
  - ADD: carry = carry out of the MSB; overflow = both operands have the same sign and the result sign differs.
  - SUB: carry = 1 when no borrow (ain >= bin unsigned); overflow = operand signs differ and the result sign differs from ain's sign.
  - INV and shifts: overflow = 0. INV also sets carry = 0.
- Illegal opcode:
  - out, carry, zero, overflow hold their previous values.
  - illegal=1 and done pulses.
  - illegal clears on the next legal completion.
- Arithmetic is WIDTH bits, two's-complement wrap; the carry is kept only as the flag.

Test Plan (WIDTH=8):
- ADD ain=8'h7F, bin=8'h01 -> done after edge k+1; out=8'h80, carry=0, overflow=1, zero=0.
- SUB ain=8'h05, bin=8'h05 -> out=8'h00, zero=1, carry=1, overflow=0. Then SUB 8'h03-8'h05, started in the done cycle -> out=8'hFE, carry=0, accepted with no gap.
- LSL ain=8'hB1, bin=3 -> busy for 4 cycles, done after edge k+4; out=8'h88, carry=1. LSL bin=0 -> done after edge k+1, out=ain, carry=0.
- ASR ain=8'h90, bin=2 -> out=8'hE4, carry=0. LSR ain=8'h90, bin=2 -> out=8'h24.
- Start an LSR with amount 7, pulse start with new operands mid-shift -> ignored, original result produced. Assert reset mid-shift -> all outputs 0 immediately, no done pulse; next start completes normally.
- opcode=4'b0111 after a result of 8'h24 -> illegal=1, done pulses, out stays 8'h24. A following ADD clears illegal.
